// File: rtl/serv_bus_sched_if.sv
// Requester (ibus/dbus) and shared memory port signals of serv_bus_sched.
// master drives the request side and memory response; slave is the scheduler.
interface serv_bus_sched_if;
  logic [31:0] i_ibus_adr;
  logic        i_ibus_cyc;
  logic [31:0] o_ibus_rdt;
  logic        o_ibus_ack;

  logic [31:0] i_dbus_adr;
  logic [31:0] i_dbus_dat;
  logic [3:0]  i_dbus_sel;
  logic        i_dbus_we;
  logic        i_dbus_cyc;
  logic [31:0] o_dbus_rdt;
  logic        o_dbus_ack;

  logic [31:0] o_wb_adr;
  logic [31:0] o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we;
  logic        o_wb_cyc;
  logic [31:0] i_wb_rdt;
  logic        i_wb_ack;

  logic        o_timeout;

  modport master (
    output i_ibus_adr, i_ibus_cyc, i_dbus_adr, i_dbus_dat, i_dbus_sel,
           i_dbus_we, i_dbus_cyc, i_wb_rdt, i_wb_ack,
    input  o_ibus_rdt, o_ibus_ack, o_dbus_rdt, o_dbus_ack, o_wb_adr,
           o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc, o_timeout
  );

  modport slave (
    input  i_ibus_adr, i_ibus_cyc, i_dbus_adr, i_dbus_dat, i_dbus_sel,
           i_dbus_we, i_dbus_cyc, i_wb_rdt, i_wb_ack,
    output o_ibus_rdt, o_ibus_ack, o_dbus_rdt, o_dbus_ack, o_wb_adr,
           o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc, o_timeout
  );
endinterface

// File: rtl/serv_bus_sched.sv
// Arbitrates ibus/dbus onto one registered memory port, dbus first, with
// abort, per-transaction timeout and a one-cycle DONE turnaround.
module serv_bus_sched #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            i_rst,
  serv_bus_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, DONE} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q;
  logic        in_gnt;
  logic        req_cyc;
  logic        ack;
  logic [31:0] rdt;
  logic        tmo;

  assign in_gnt  = (state_q == GNT_I) || (state_q == GNT_D);
  assign req_cyc = (state_q == GNT_D) ? bus.i_dbus_cyc : bus.i_ibus_cyc;

  always_ff @(posedge clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ack     = 1'b0;
    rdt     = 32'h0;
    tmo     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_dbus_cyc)      state_d = GNT_D;
        else if (bus.i_ibus_cyc) state_d = GNT_I;
      end
      GNT_I, GNT_D: begin
        // Memory ack beats both abort and timeout in the same cycle.
        if (bus.i_wb_ack) begin
          ack     = 1'b1;
          rdt     = bus.i_wb_rdt;
          state_d = DONE;
        end else if (!req_cyc) begin
          state_d = DONE;
        end else if (cnt_q == TMO_LAST) begin
          ack     = 1'b1;
          tmo     = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (i_rst) begin
      ack = 1'b0;
      rdt = 32'h0;
      tmo = 1'b0;
    end
  end

  assign bus.o_ibus_ack = ack && (state_q == GNT_I);
  assign bus.o_ibus_rdt = bus.o_ibus_ack ? rdt : 32'h0;
  assign bus.o_dbus_ack = ack && (state_q == GNT_D);
  assign bus.o_dbus_rdt = bus.o_dbus_ack ? rdt : 32'h0;
  assign bus.o_timeout  = tmo;

  always_ff @(posedge clk) begin
    if (i_rst || !in_gnt) cnt_q <= 8'h0;
    else                  cnt_q <= cnt_q + 8'h1;
  end

  // Request fields are latched only on the grant edge and held until the next grant.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      bus.o_wb_adr <= 32'h0;
      bus.o_wb_dat <= 32'h0;
      bus.o_wb_sel <= 4'h0;
      bus.o_wb_we  <= 1'b0;
      bus.o_wb_cyc <= 1'b0;
    end else if (state_q == IDLE && state_d == GNT_D) begin
      bus.o_wb_adr <= bus.i_dbus_adr;
      bus.o_wb_dat <= bus.i_dbus_dat;
      bus.o_wb_sel <= bus.i_dbus_sel;
      bus.o_wb_we  <= bus.i_dbus_we;
      bus.o_wb_cyc <= 1'b1;
    end else if (state_q == IDLE && state_d == GNT_I) begin
      bus.o_wb_adr <= bus.i_ibus_adr;
      bus.o_wb_dat <= 32'h0;
      bus.o_wb_sel <= 4'hF;
      bus.o_wb_we  <= 1'b0;
      bus.o_wb_cyc <= 1'b1;
    end else if (in_gnt && state_d == DONE) begin
      bus.o_wb_cyc <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serv_bus_sched.sv
// Transaction-level bench for serv_bus_sched: directed cases plus randomized
// traffic checked against a per-transaction outcome model.
module tb_serv_bus_sched;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic i_rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   scramble = 1'b0;

  serv_bus_sched_if bus();

  serv_bus_sched #(.TIMEOUT(TMO)) dut (
    .clk   (clk),
    .i_rst (i_rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_wbcyc"}, 32'(bus.o_wb_cyc), 32'h0);
    chk({tag, "_iack"},  32'(bus.o_ibus_ack), 32'h0);
    chk({tag, "_dack"},  32'(bus.o_dbus_ack), 32'h0);
    chk({tag, "_irdt"},  bus.o_ibus_rdt, 32'h0);
    chk({tag, "_drdt"},  bus.o_dbus_rdt, 32'h0);
    chk({tag, "_tmo"},   32'(bus.o_timeout), 32'h0);
  endtask

  // Called at the start of an IDLE cycle with request lines already set.
  // d: grant cycle index carrying i_wb_ack (<0 none); a: grant cycle index
  // from which the winner drops cyc (<0 never).
  task automatic run_txn(input int d, input int a);
    bit          dwin, fin, wcyc, e_ack, e_tmo;
    logic [31:0] e_adr, e_dat, r, e_rdt;
    logic [3:0]  e_sel;
    logic        e_we;
    dwin = bus.i_dbus_cyc;
    if (dwin) begin
      e_adr = bus.i_dbus_adr; e_dat = bus.i_dbus_dat;
      e_sel = bus.i_dbus_sel; e_we  = bus.i_dbus_we;
    end else begin
      e_adr = bus.i_ibus_adr; e_dat = 32'h0; e_sel = 4'hF; e_we = 1'b0;
    end
    bus.i_wb_ack = 1'($urandom_range(0, 1));
    bus.i_wb_rdt = $urandom;
    @(negedge clk);
    chk_quiet("idle");
    next_cycle();
    fin = 1'b0;
    for (int j = 0; !fin && j < 300; j++) begin
      r = $urandom;
      bus.i_wb_ack = (j == d);
      bus.i_wb_rdt = r;
      if (a >= 0 && j >= a) begin
        if (dwin) bus.i_dbus_cyc = 1'b0;
        else      bus.i_ibus_cyc = 1'b0;
      end
      if (scramble) begin
        bus.i_ibus_adr = $urandom; bus.i_dbus_adr = $urandom;
        bus.i_dbus_dat = $urandom; bus.i_dbus_sel = 4'($urandom);
        bus.i_dbus_we  = 1'($urandom);
      end
      wcyc  = dwin ? bus.i_dbus_cyc : bus.i_ibus_cyc;
      e_ack = 1'b0; e_rdt = 32'h0; e_tmo = 1'b0;
      if (j == d) begin
        e_ack = 1'b1; e_rdt = r; fin = 1'b1;
      end else if (!wcyc) begin
        fin = 1'b1;
      end else if (j == TMO - 1) begin
        e_ack = 1'b1; e_tmo = 1'b1; fin = 1'b1;
      end
      @(negedge clk);
      chk("gnt_wbcyc", 32'(bus.o_wb_cyc), 32'h1);
      chk("gnt_adr",   bus.o_wb_adr, e_adr);
      chk("gnt_dat",   bus.o_wb_dat, e_dat);
      chk("gnt_sel",   32'(bus.o_wb_sel), 32'(e_sel));
      chk("gnt_we",    32'(bus.o_wb_we), 32'(e_we));
      chk("gnt_iack",  32'(bus.o_ibus_ack), dwin ? 32'h0 : 32'(e_ack));
      chk("gnt_irdt",  bus.o_ibus_rdt, dwin ? 32'h0 : e_rdt);
      chk("gnt_dack",  32'(bus.o_dbus_ack), dwin ? 32'(e_ack) : 32'h0);
      chk("gnt_drdt",  bus.o_dbus_rdt, dwin ? e_rdt : 32'h0);
      chk("gnt_tmo",   32'(bus.o_timeout), 32'(e_tmo));
      next_cycle();
    end
    if (!fin) chk("gnt_bound", 32'h0, 32'h1);
    // DONE cycle: winner releases, stray memory acks must be ignored.
    if (dwin) bus.i_dbus_cyc = 1'b0;
    else      bus.i_ibus_cyc = 1'b0;
    bus.i_wb_ack = 1'($urandom_range(0, 1));
    bus.i_wb_rdt = $urandom;
    @(negedge clk);
    chk_quiet("done");
    next_cycle();
  endtask

  initial begin
    int d, a;
    bus.i_ibus_adr = 32'h0; bus.i_ibus_cyc = 1'b0;
    bus.i_dbus_adr = 32'h0; bus.i_dbus_dat = 32'h0; bus.i_dbus_sel = 4'h0;
    bus.i_dbus_we  = 1'b0;  bus.i_dbus_cyc = 1'b0;
    bus.i_wb_rdt   = 32'h0; bus.i_wb_ack   = 1'b0;
    i_rst = 1'b1;
    repeat (2) next_cycle();
    @(negedge clk);
    chk_quiet("rst");
    chk("rst_adr", bus.o_wb_adr, 32'h0);
    chk("rst_dat", bus.o_wb_dat, 32'h0);
    chk("rst_sel", 32'(bus.o_wb_sel), 32'h0);
    chk("rst_we",  32'(bus.o_wb_we), 32'h0);
    next_cycle();
    i_rst = 1'b0;

    // ibus fetch, ack two cycles after the request
    bus.i_ibus_cyc = 1'b1; bus.i_ibus_adr = 32'h100;
    run_txn(1, -1);
    bus.i_ibus_adr = 32'h0;

    // simultaneous requests: dbus first, ibus after DONE
    bus.i_ibus_cyc = 1'b1; bus.i_ibus_adr = 32'h200;
    bus.i_dbus_cyc = 1'b1; bus.i_dbus_adr = 32'h1000; bus.i_dbus_we = 1'b1;
    bus.i_dbus_dat = 32'hDEADBEEF; bus.i_dbus_sel = 4'h3;
    run_txn(1, -1);
    run_txn(0, -1);

    // timeout, then ack on the timeout cycle, then abort
    bus.i_dbus_cyc = 1'b1; bus.i_dbus_we = 1'b0; bus.i_dbus_adr = 32'h40;
    run_txn(-1, -1);
    bus.i_dbus_cyc = 1'b1;
    run_txn(TMO - 1, -1);
    bus.i_dbus_cyc = 1'b1;
    run_txn(-1, 1);

    // reset in the middle of an ibus grant, with a simultaneous memory ack
    bus.i_ibus_cyc = 1'b1; bus.i_ibus_adr = 32'h300;
    next_cycle();
    i_rst = 1'b1; bus.i_wb_ack = 1'b1; bus.i_wb_rdt = 32'h1234;
    @(negedge clk);
    chk("rstg_iack", 32'(bus.o_ibus_ack), 32'h0);
    chk("rstg_irdt", bus.o_ibus_rdt, 32'h0);
    next_cycle();
    i_rst = 1'b0; bus.i_ibus_cyc = 1'b0;
    @(negedge clk);
    chk_quiet("rstg_after");
    chk("rstg_adr", bus.o_wb_adr, 32'h0);
    next_cycle();
    bus.i_dbus_cyc = 1'b1; bus.i_dbus_adr = 32'h500;
    run_txn(0, -1);

    // randomized traffic
    scramble = 1'b1;
    for (int n = 0; n < 150; n++) begin
      if (!bus.i_ibus_cyc && !bus.i_dbus_cyc) begin
        bus.i_ibus_cyc = 1'($urandom_range(0, 1));
        bus.i_dbus_cyc = 1'($urandom_range(0, 1));
        bus.i_ibus_adr = $urandom; bus.i_dbus_adr = $urandom;
        bus.i_dbus_dat = $urandom; bus.i_dbus_sel = 4'($urandom);
        bus.i_dbus_we  = 1'($urandom);
      end
      if (!bus.i_ibus_cyc && !bus.i_dbus_cyc) begin
        bus.i_wb_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk_quiet("gap");
        next_cycle();
      end else begin
        d = int'($urandom_range(0, 6)) - 1;
        a = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 4)) : -1;
        run_txn(d, a);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
